// File: rtl/alu_op_issuer_pkg.sv
// Shared definitions for the ALU issue path: select codes, MIPS opcode/funct values and FSM states.
// The ALU imports the same package so both sides agree on sel encoding.
package alu_op_issuer_pkg;

   localparam logic [3:0] SEL_AND  = 4'b0000;
   localparam logic [3:0] SEL_OR   = 4'b0001;
   localparam logic [3:0] SEL_ADD  = 4'b0010;
   localparam logic [3:0] SEL_NOR  = 4'b0100;
   localparam logic [3:0] SEL_MUL  = 4'b0101;
   localparam logic [3:0] SEL_SUB  = 4'b0110;
   localparam logic [3:0] SEL_XOR  = 4'b0111;
   localparam logic [3:0] SEL_DIV  = 4'b1000;
   localparam logic [3:0] SEL_SLT  = 4'b1001;
   localparam logic [3:0] SEL_ZERO = 4'b1101;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_MUL = 6'b011000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_DIV = 6'b011010;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct into ALU select, b operand and op class.
// Anything not listed in the decode table is flagged illegal.
module alu_op_decode
   import alu_op_issuer_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   input  logic [W-1:0] op_b,
   input  logic [15:0]  imm,
   output logic [3:0]   sel,
   output logic [W-1:0] b_operand,
   output logic         is_muldiv,
   output logic         illegal
);

   logic [W-1:0] imm_sext;
   logic [W-1:0] imm_zext;

   assign imm_sext = {{(W-16){imm[15]}}, imm};
   assign imm_zext = {{(W-16){1'b0}}, imm};

   always_comb begin
      sel       = SEL_ZERO;
      b_operand = op_b;
      illegal   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_AND:  sel = SEL_AND;
               FN_OR:   sel = SEL_OR;
               FN_ADD:  sel = SEL_ADD;
               FN_NOR:  sel = SEL_NOR;
               FN_MUL:  sel = SEL_MUL;
               FN_SUB:  sel = SEL_SUB;
               FN_XOR:  sel = SEL_XOR;
               FN_DIV:  sel = SEL_DIV;
               FN_SLT:  sel = SEL_SLT;
               default: illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: begin
            sel       = SEL_ADD;
            b_operand = imm_sext;
         end
         OP_SLTI: begin
            sel       = SEL_SLT;
            b_operand = imm_sext;
         end
         OP_ANDI: begin
            sel       = SEL_AND;
            b_operand = imm_zext;
         end
         OP_ORI: begin
            sel       = SEL_OR;
            b_operand = imm_zext;
         end
         OP_XORI: begin
            sel       = SEL_XOR;
            b_operand = imm_zext;
         end
         OP_BEQ:  sel = SEL_SUB;
         default: illegal = 1'b1;
      endcase
   end

   assign is_muldiv = (sel == SEL_MUL) || (sel == SEL_DIV);

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one decoded request to the combinational ALU, waits its settle latency,
// and returns the captured result over a valid/ready port.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for a request; ALU driven with ZERO
// EXEC    | ALU inputs held, down-counter running until terminal count 1
// DONE    | result (or error) presented, waiting for out_ready
module alu_op_issuer
   import alu_op_issuer_pkg::*;
#(
   parameter int W          = 32,
   parameter int ALU_LAT    = 1,
   parameter int MULDIV_LAT = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic [15:0]  imm,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_sel,
   input  logic [W-1:0] alu_res,
   input  logic         alu_zf,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_res,
   output logic         out_zf,
   output logic         out_err
);

   localparam int LAT_MAX = (ALU_LAT > MULDIV_LAT) ? ALU_LAT : MULDIV_LAT;
   localparam int CNT_W   = $clog2(LAT_MAX) + 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]       alu_a_q, alu_a_d;
   logic [W-1:0]       alu_b_q, alu_b_d;
   logic [3:0]         alu_sel_q, alu_sel_d;
   logic [W-1:0]       out_res_q, out_res_d;
   logic               out_zf_q, out_zf_d;
   logic               out_err_q, out_err_d;

   logic [3:0]         dec_sel;
   logic [W-1:0]       dec_b;
   logic               dec_muldiv;
   logic               dec_illegal;
   logic               reject;

   alu_op_decode #(.W(W)) u_decode (
      .opcode    (opcode),
      .funct     (funct),
      .op_b      (op_b),
      .imm       (imm),
      .sel       (dec_sel),
      .b_operand (dec_b),
      .is_muldiv (dec_muldiv),
      .illegal   (dec_illegal)
   );

   // Divide-by-zero never reaches the ALU; it is answered directly as an error.
   assign reject = dec_illegal || ((dec_sel == SEL_DIV) && (dec_b == '0));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_sel_d = alu_sel_q;
      out_res_d = out_res_q;
      out_zf_d  = out_zf_q;
      out_err_d = out_err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (reject) begin
                  out_err_d = 1'b1;
                  out_res_d = '0;
                  out_zf_d  = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  alu_a_d   = op_a;
                  alu_b_d   = dec_b;
                  alu_sel_d = dec_sel;
                  cnt_d     = dec_muldiv ? CNT_W'(MULDIV_LAT) : CNT_W'(ALU_LAT);
                  state_d   = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               out_res_d = alu_res;
               out_zf_d  = alu_zf;
               out_err_d = 1'b0;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               alu_sel_d = SEL_ZERO;
               alu_a_d   = '0;
               alu_b_d   = '0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= SEL_ZERO;
         out_res_q <= '0;
         out_zf_q  <= 1'b0;
         out_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_sel_q <= alu_sel_d;
         out_res_q <= out_res_d;
         out_zf_q  <= out_zf_d;
         out_err_q <= out_err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign out_res   = out_res_q;
   assign out_zf    = out_zf_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural combinational ALU on the far side.
module tb_alu_op_issuer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  opcode = '0;
   logic [5:0]  funct = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [15:0] imm = '0;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_sel;
   logic [31:0] alu_res;
   logic        alu_zf;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_res;
   logic        out_zf;
   logic        out_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_op_issuer #(.W(32), .ALU_LAT(1), .MULDIV_LAT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .funct     (funct),
      .op_a      (op_a),
      .op_b      (op_b),
      .imm       (imm),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_res   (alu_res),
      .alu_zf    (alu_zf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_zf    (out_zf),
      .out_err   (out_err)
   );

   always_comb begin
      alu_res = '0;
      case (alu_sel)
         4'b0000: alu_res = alu_a & alu_b;
         4'b0001: alu_res = alu_a | alu_b;
         4'b0010: alu_res = alu_a + alu_b;
         4'b0100: alu_res = ~(alu_a | alu_b);
         4'b0101: alu_res = alu_a * alu_b;
         4'b0110: alu_res = alu_a - alu_b;
         4'b0111: alu_res = alu_a ^ alu_b;
         4'b1000: alu_res = (alu_b == 0) ? 32'd0 : alu_a / alu_b;
         4'b1001: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_res = '0;
      endcase
   end
   assign alu_zf = (alu_res == 32'd0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one request, returns sel seen right after accept, edges until out_valid, and
   // whether sel moved while waiting.
   task automatic run_op(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] im,
                         output logic [3:0] sel_exec, output int lat, output logic sel_bad);
      @(negedge clk);
      opcode = opc; funct = fn; op_a = a; op_b = b; imm = im; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sel_exec = alu_sel;
      sel_bad = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (alu_sel !== sel_exec) sel_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   logic [3:0] sel_x;
   logic       bad;
   int         lat;
   logic [31:0] hold_res;
   logic       seen;

   initial begin
      #12;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_res", out_res, 32'd0);
      check("rst_out_zf_err", {30'b0, out_zf, out_err}, 32'd0);
      check("rst_alu_ab", alu_a | alu_b, 32'd0);
      check("rst_alu_sel", {28'b0, alu_sel}, 32'hD);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD 5+7
      run_op(6'b000000, 6'b100000, 32'd5, 32'd7, 16'h0, sel_x, lat, bad);
      check("add_sel", {28'b0, sel_x}, 32'h2);
      check("add_lat", lat, 32'd1);
      check("add_res", out_res, 32'd12);
      check("add_zf_err", {30'b0, out_zf, out_err}, 32'd0);
      consume();
      check("add_done_sel", {28'b0, alu_sel}, 32'hD);
      check("add_done_ready", {30'b0, in_ready, out_valid}, 32'd2);

      // MUL 6*7
      run_op(6'b000000, 6'b011000, 32'd6, 32'd7, 16'h0, sel_x, lat, bad);
      check("mul_sel", {28'b0, sel_x}, 32'h5);
      check("mul_sel_hold", {31'b0, bad}, 32'd0);
      check("mul_lat", lat, 32'd4);
      check("mul_res", out_res, 32'd42);
      consume();

      // DIV 42/6
      run_op(6'b000000, 6'b011010, 32'd42, 32'd6, 16'h0, sel_x, lat, bad);
      check("div_sel", {28'b0, sel_x}, 32'h8);
      check("div_lat", lat, 32'd4);
      check("div_res", out_res, 32'd7);
      consume();

      // DIV by zero: answered without an ALU issue
      run_op(6'b000000, 6'b011010, 32'd9, 32'd0, 16'h0, sel_x, lat, bad);
      check("dz_sel", {28'b0, sel_x}, 32'hD);
      check("dz_lat", lat, 32'd0);
      check("dz_valid", {31'b0, out_valid}, 32'd1);
      check("dz_res", out_res, 32'd0);
      check("dz_zf_err", {30'b0, out_zf, out_err}, 32'd3);
      consume();

      // Illegal R-type funct
      run_op(6'b000000, 6'b111111, 32'd1, 32'd1, 16'h0, sel_x, lat, bad);
      check("ill_zf_err", {30'b0, out_zf, out_err}, 32'd3);
      check("ill_sel", {28'b0, alu_sel}, 32'hD);
      consume();

      // andi zero-extends
      run_op(6'b001100, 6'b000000, 32'h1234_5678, 32'hDEAD_BEEF, 16'hFFFF, sel_x, lat, bad);
      check("andi_b", alu_b, 32'h0000_FFFF);
      check("andi_res", out_res, 32'h0000_5678);
      check("andi_err", {31'b0, out_err}, 32'd0);
      consume();

      // addi sign-extends
      run_op(6'b001000, 6'b000000, 32'd1, 32'd0, 16'hFFFF, sel_x, lat, bad);
      check("addi_b", alu_b, 32'hFFFF_FFFF);
      check("addi_res", out_res, 32'd0);
      check("addi_zf", {31'b0, out_zf}, 32'd1);
      consume();

      // SLT signed: -3 < 2
      run_op(6'b000000, 6'b101010, 32'hFFFF_FFFD, 32'd2, 16'h0, sel_x, lat, bad);
      check("slt_res", out_res, 32'd1);
      consume();

      // beq equal operands -> SUB, zero
      run_op(6'b000100, 6'b000000, 32'd77, 32'd77, 16'h0, sel_x, lat, bad);
      check("beq_sel", {28'b0, sel_x}, 32'h6);
      check("beq_res_zf", {out_res[30:0], out_zf}, 32'd1);

      // Backpressure: hold off out_ready with a competing request on the input
      consume();
      run_op(6'b000000, 6'b100010, 32'd9, 32'd4, 16'h0, sel_x, lat, bad);
      hold_res = out_res;
      check("bp_first_res", hold_res, 32'd5);
      @(negedge clk);
      opcode = 6'b000000; funct = 6'b100000; op_a = 32'd100; op_b = 32'd200; in_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("bp_res_stable", out_res, 32'd5);
      check("bp_flags", {29'b0, out_valid, in_ready, out_err}, 32'd4);
      check("bp_sel_held", {28'b0, alu_sel}, 32'h6);
      in_valid = 1'b0;
      consume();
      check("bp_release_sel", {28'b0, alu_sel}, 32'hD);
      check("bp_release_ready", {30'b0, in_ready, out_valid}, 32'd2);

      // Async reset mid-EXEC of a MUL
      @(negedge clk);
      opcode = 6'b000000; funct = 6'b011000; op_a = 32'd3; op_b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("ar_sel", {28'b0, alu_sel}, 32'hD);
      check("ar_ready_valid", {30'b0, in_ready, out_valid}, 32'd2);
      check("ar_alu_a", alu_a, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("ar_no_valid", {31'b0, seen}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
